// File: rtl/rob_nway.sv
// rob_nway: reorder buffer with DEPTH entries, CDB_N completion ports and two
// combinational operand lookups. The tag of an entry is its index.
// Optional feature: define ROB_CDB_FWD_EN to forward same-cycle CDB results
// onto the lookup ports.
module rob_nway #(
    parameter int DEPTH     = 16,
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5,
    parameter int CDB_N     = 2,
    localparam int TAG_W    = $clog2(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   disp_valid,
    input  logic [REG_IDX_W-1:0]   disp_dest_idx,
    output logic                   disp_ready,
    output logic [TAG_W-1:0]       disp_tag,
    input  logic [CDB_N-1:0]       cdb_valid,
    input  logic [CDB_N*TAG_W-1:0] cdb_tag,
    input  logic [CDB_N*XLEN-1:0]  cdb_value,
    input  logic [CDB_N-1:0]       cdb_mispredict,
    input  logic [2*TAG_W-1:0]     lk_tag,
    output logic [1:0]             lk_ready,
    output logic [2*XLEN-1:0]      lk_value,
    output logic                   ret_valid,
    output logic [REG_IDX_W-1:0]   ret_dest_idx,
    output logic [XLEN-1:0]        ret_value,
    output logic [TAG_W-1:0]       ret_tag,
    output logic                   ret_flush,
    output logic [TAG_W:0]         count,
    output logic                   empty
);

    localparam int CNT_W = TAG_W + 1;

    logic [DEPTH-1:0]                busy_q, busy_d;
    logic [DEPTH-1:0]                done_q, done_d;
    logic [DEPTH-1:0]                mispred_q, mispred_d;
    logic [DEPTH-1:0][REG_IDX_W-1:0] dest_q, dest_d;
    logic [DEPTH-1:0][XLEN-1:0]      value_q, value_d;
    logic [TAG_W-1:0]                head_q, head_d;
    logic [TAG_W-1:0]                tail_q, tail_d;
    logic [CNT_W-1:0]                count_q, count_d;

    logic full;
    logic dispatch;

    // Handshake and retire signals derived from the registered state only.
    always_comb begin
        full         = (count_q == CNT_W'(DEPTH));
        disp_ready   = !full;
        disp_tag     = tail_q;
        ret_valid    = busy_q[head_q] && done_q[head_q];
        ret_flush    = ret_valid && mispred_q[head_q];
        ret_dest_idx = dest_q[head_q];
        ret_value    = value_q[head_q];
        ret_tag      = head_q;
        dispatch     = disp_valid && disp_ready && !ret_flush;
        count        = count_q;
        empty        = (count_q == '0);
    end

    // Next-state: CDB writes, then retire, then dispatch; a flush overrides all.
    always_comb begin
        busy_d    = busy_q;
        done_d    = done_q;
        mispred_d = mispred_q;
        dest_d    = dest_q;
        value_d   = value_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        // Walk ports high to low so the lowest-numbered port is written last.
        for (int p = CDB_N - 1; p >= 0; p--) begin
            if (cdb_valid[p] && busy_q[cdb_tag[p*TAG_W +: TAG_W]]) begin
                done_d[cdb_tag[p*TAG_W +: TAG_W]]    = 1'b1;
                value_d[cdb_tag[p*TAG_W +: TAG_W]]   = cdb_value[p*XLEN +: XLEN];
                mispred_d[cdb_tag[p*TAG_W +: TAG_W]] = cdb_mispredict[p];
            end
        end

        if (ret_valid) begin
            busy_d[head_q] = 1'b0;
            done_d[head_q] = 1'b0;
            head_d         = head_q + TAG_W'(1);
        end

        // The tail slot is never busy while not full, so it cannot collide with a CDB hit.
        if (dispatch) begin
            busy_d[tail_q]    = 1'b1;
            done_d[tail_q]    = 1'b0;
            mispred_d[tail_q] = 1'b0;
            value_d[tail_q]   = '0;
            dest_d[tail_q]    = disp_dest_idx;
            tail_d            = tail_q + TAG_W'(1);
        end

        unique case ({dispatch, ret_valid})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (ret_flush) begin
            busy_d    = '0;
            done_d    = '0;
            mispred_d = '0;
            dest_d    = dest_q;
            value_d   = value_q;
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
        end
    end

    // State registers; reset drops every entry at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q    <= '0;
            done_q    <= '0;
            mispred_q <= '0;
            dest_q    <= '0;
            value_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            mispred_q <= mispred_d;
            dest_q    <= dest_d;
            value_q   <= value_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    // Operand lookups read pre-update state, optionally overlaid with CDB forwarding.
    always_comb begin
        lk_ready = '0;
        lk_value = '0;
        for (int l = 0; l < 2; l++) begin
            if (busy_q[lk_tag[l*TAG_W +: TAG_W]] && done_q[lk_tag[l*TAG_W +: TAG_W]]) begin
                lk_ready[l]              = 1'b1;
                lk_value[l*XLEN +: XLEN] = value_q[lk_tag[l*TAG_W +: TAG_W]];
            end
`ifdef ROB_CDB_FWD_EN
            if (!ret_flush && busy_q[lk_tag[l*TAG_W +: TAG_W]]) begin
                for (int p = CDB_N - 1; p >= 0; p--) begin
                    if (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == lk_tag[l*TAG_W +: TAG_W])) begin
                        lk_ready[l]              = 1'b1;
                        lk_value[l*XLEN +: XLEN] = cdb_value[p*XLEN +: XLEN];
                    end
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_rob_nway.sv
// tb_rob_nway: directed bench for rob_nway (DEPTH=16, CDB_N=2). Retirements
// are checked by a monitor against a queue of expected retire records.
module tb_rob_nway;

    logic        clock;
    logic        reset_n;
    logic        disp_valid;
    logic [4:0]  disp_dest_idx;
    logic        disp_ready;
    logic [3:0]  disp_tag;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_value;
    logic [1:0]  cdb_mispredict;
    logic [7:0]  lk_tag;
    logic [1:0]  lk_ready;
    logic [63:0] lk_value;
    logic        ret_valid;
    logic [4:0]  ret_dest_idx;
    logic [31:0] ret_value;
    logic [3:0]  ret_tag;
    logic        ret_flush;
    logic [4:0]  count;
    logic        empty;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] value;
        logic [3:0]  tag;
        logic        flush;
    } ret_t;

    ret_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    rob_nway dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .disp_valid     (disp_valid),
        .disp_dest_idx  (disp_dest_idx),
        .disp_ready     (disp_ready),
        .disp_tag       (disp_tag),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_value      (cdb_value),
        .cdb_mispredict (cdb_mispredict),
        .lk_tag         (lk_tag),
        .lk_ready       (lk_ready),
        .lk_value       (lk_value),
        .ret_valid      (ret_valid),
        .ret_dest_idx   (ret_dest_idx),
        .ret_value      (ret_value),
        .ret_tag        (ret_tag),
        .ret_flush      (ret_flush),
        .count          (count),
        .empty          (empty)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete (got running, required finished)");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic dv, input logic [4:0] dest, input logic [1:0] cv,
                                 input logic [3:0] t0, input logic [31:0] v0, input logic m0,
                                 input logic [3:0] t1, input logic [31:0] v1, input logic m1,
                                 input logic [3:0] l0, input logic [3:0] l1);
        disp_valid     = dv;
        disp_dest_idx  = dest;
        cdb_valid      = cv;
        cdb_tag        = {t1, t0};
        cdb_value      = {v1, v0};
        cdb_mispredict = {m1, m0};
        lk_tag         = {l1, l0};
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 2'b00, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
    endtask

    task automatic endCycle();
        @(posedge clock);
        #1;
        idle();
    endtask

    function automatic ret_t mkRet(input logic [4:0] d, input logic [31:0] v, input logic [3:0] t, input logic f);
        ret_t r;
        r.dest  = d;
        r.value = v;
        r.tag   = t;
        r.flush = f;
        return r;
    endfunction

    // Monitor: every retirement seen mid-cycle is matched against the queue head.
    always @(negedge clock) begin
        if (reset_n && ret_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_retire_tag", {60'd0, ret_tag}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                ret_t e;
                e = exp_q.pop_front();
                checkOutput("ret_tag", {60'd0, ret_tag}, {60'd0, e.tag});
                checkOutput("ret_dest_idx", {59'd0, ret_dest_idx}, {59'd0, e.dest});
                checkOutput("ret_value", {32'd0, ret_value}, {32'd0, e.value});
                checkOutput("ret_flush", {63'd0, ret_flush}, {63'd0, e.flush});
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        idle();

        // Reset values while held in reset
        #12;
        checkOutput("rst_disp_ready", {63'd0, disp_ready}, 64'd1);
        checkOutput("rst_disp_tag", {60'd0, disp_tag}, 64'd0);
        checkOutput("rst_ret_valid", {63'd0, ret_valid}, 64'd0);
        checkOutput("rst_ret_flush", {63'd0, ret_flush}, 64'd0);
        checkOutput("rst_lk_ready", {62'd0, lk_ready}, 64'd0);
        checkOutput("rst_lk_value", lk_value, 64'd0);
        checkOutput("rst_count", {59'd0, count}, 64'd0);
        checkOutput("rst_empty", {63'd0, empty}, 64'd1);
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Fill the ROB: tags 0..15, dest = tag+1
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 5'(i + 1), 2'b00, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
            @(negedge clock);
            checkOutput("fill_disp_tag", {60'd0, disp_tag}, 64'(i));
            checkOutput("fill_disp_ready", {63'd0, disp_ready}, 64'd1);
            endCycle();
        end
        applyStimulus(1'b1, 5'd31, 2'b00, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
        @(negedge clock);
        checkOutput("full_disp_ready", {63'd0, disp_ready}, 64'd0);
        checkOutput("full_count", {59'd0, count}, 64'd16);
        endCycle();
        checkOutput("after17_count", {59'd0, count}, 64'd16);

        // Out-of-order completion: tag 1 first, then tag 0
        exp_q.push_back(mkRet(5'd1, 32'h55, 4'd0, 1'b0));
        exp_q.push_back(mkRet(5'd2, 32'hAA, 4'd1, 1'b0));
        applyStimulus(1'b0, 5'd0, 2'b01, 4'd1, 32'hAA, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
        @(negedge clock);
        checkOutput("ooo_no_retire", {63'd0, ret_valid}, 64'd0);
        endCycle();
        applyStimulus(1'b0, 5'd0, 2'b01, 4'd0, 32'h55, 1'b0, 4'd0, 32'd0, 1'b0, 4'd1, 4'd0);
        @(negedge clock);
        checkOutput("ooo_still_no_retire", {63'd0, ret_valid}, 64'd0);
`ifdef ROB_CDB_FWD_EN
        checkOutput("ooo_lk_ready", {62'd0, lk_ready}, 64'd3);
        checkOutput("ooo_lk_value", lk_value, {32'h55, 32'hAA});
`else
        checkOutput("ooo_lk_ready", {62'd0, lk_ready}, 64'd1);
        checkOutput("ooo_lk_value", lk_value, {32'h0, 32'hAA});
`endif
        endCycle();
        // Full: retire head while attempting dispatch -> dispatch rejected
        applyStimulus(1'b1, 5'd21, 2'b00, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
        @(negedge clock);
        checkOutput("full_retire_disp_ready", {63'd0, disp_ready}, 64'd0);
        checkOutput("full_retire_valid", {63'd0, ret_valid}, 64'd1);
        endCycle();
        // Next cycle the freed slot accepts a dispatch at wrapped tag 0
        applyStimulus(1'b1, 5'd20, 2'b00, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
        @(negedge clock);
        checkOutput("wrap_count", {59'd0, count}, 64'd15);
        checkOutput("wrap_disp_ready", {63'd0, disp_ready}, 64'd1);
        checkOutput("wrap_disp_tag", {60'd0, disp_tag}, 64'd0);
        endCycle();
        checkOutput("wrap_count_after", {59'd0, count}, 64'd15);

        reset_n = 1'b0;
        #1 reset_n = 1'b1;

        // Mispredict flush on head tag 3 with tags 3..7 busy
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 5'(i + 8), 2'b00, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
            endCycle();
        end
        exp_q.push_back(mkRet(5'd8, 32'h100, 4'd0, 1'b0));
        exp_q.push_back(mkRet(5'd9, 32'h101, 4'd1, 1'b0));
        exp_q.push_back(mkRet(5'd10, 32'h102, 4'd2, 1'b0));
        exp_q.push_back(mkRet(5'd11, 32'h103, 4'd3, 1'b1));
        applyStimulus(1'b0, 5'd0, 2'b11, 4'd0, 32'h100, 1'b0, 4'd1, 32'h101, 1'b0, 4'd0, 4'd0);
        endCycle();
        applyStimulus(1'b0, 5'd0, 2'b11, 4'd2, 32'h102, 1'b0, 4'd3, 32'h103, 1'b1, 4'd0, 4'd0);
        endCycle();
        endCycle();
        @(negedge clock);
        checkOutput("pre_flush_ret_flush", {63'd0, ret_flush}, 64'd0);
        endCycle();
        applyStimulus(1'b1, 5'd5, 2'b01, 4'd4, 32'h44, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
        @(negedge clock);
        checkOutput("flush_ret_flush", {63'd0, ret_flush}, 64'd1);
        checkOutput("flush_count", {59'd0, count}, 64'd5);
        endCycle();
        applyStimulus(1'b0, 5'd0, 2'b00, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd4, 4'd0);
        @(negedge clock);
        checkOutput("post_flush_count", {59'd0, count}, 64'd0);
        checkOutput("post_flush_empty", {63'd0, empty}, 64'd1);
        checkOutput("post_flush_disp_tag", {60'd0, disp_tag}, 64'd0);
        checkOutput("post_flush_ret_flush", {63'd0, ret_flush}, 64'd0);
        checkOutput("post_flush_lk_ready", {62'd0, lk_ready}, 64'd0);
        endCycle();

        // Two ports on tag 2: port 0 (value 7) wins over port 1 (value 9)
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'(i + 1), 2'b00, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
            endCycle();
        end
        applyStimulus(1'b0, 5'd0, 2'b11, 4'd2, 32'd7, 1'b0, 4'd2, 32'd9, 1'b0, 4'd2, 4'd5);
        @(negedge clock);
`ifdef ROB_CDB_FWD_EN
        checkOutput("dual_fwd_lk_ready", {62'd0, lk_ready}, 64'd1);
        checkOutput("dual_fwd_lk_value", lk_value, 64'd7);
`else
        checkOutput("dual_fwd_lk_ready", {62'd0, lk_ready}, 64'd0);
        checkOutput("dual_fwd_lk_value", lk_value, 64'd0);
`endif
        endCycle();
        // A CDB hit on non-busy tag 5 must be ignored
        applyStimulus(1'b0, 5'd0, 2'b01, 4'd5, 32'h77, 1'b0, 4'd0, 32'd0, 1'b0, 4'd2, 4'd5);
        @(negedge clock);
        checkOutput("dual_lk_ready", {62'd0, lk_ready}, 64'd1);
        checkOutput("dual_lk_value", lk_value, 64'd7);
        endCycle();
        applyStimulus(1'b0, 5'd0, 2'b00, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd2, 4'd5);
        @(negedge clock);
        checkOutput("nonbusy_lk_ready", {62'd0, lk_ready}, 64'd1);
        checkOutput("nonbusy_lk_value", lk_value, 64'd7);
        checkOutput("three_busy_no_retire", {63'd0, ret_valid}, 64'd0);
        endCycle();

        // Asynchronous reset mid-cycle with 4 entries busy and head ready to retire
        applyStimulus(1'b1, 5'd4, 2'b00, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
        endCycle();
        applyStimulus(1'b0, 5'd0, 2'b01, 4'd0, 32'h11, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
        endCycle();
        applyStimulus(1'b0, 5'd0, 2'b00, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd2);
        checkOutput("pre_reset_count", {59'd0, count}, 64'd4);
        checkOutput("pre_reset_ret_valid", {63'd0, ret_valid}, 64'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("async_disp_ready", {63'd0, disp_ready}, 64'd1);
        checkOutput("async_disp_tag", {60'd0, disp_tag}, 64'd0);
        checkOutput("async_ret_valid", {63'd0, ret_valid}, 64'd0);
        checkOutput("async_ret_flush", {63'd0, ret_flush}, 64'd0);
        checkOutput("async_lk_ready", {62'd0, lk_ready}, 64'd0);
        checkOutput("async_lk_value", lk_value, 64'd0);
        checkOutput("async_count", {59'd0, count}, 64'd0);
        checkOutput("async_empty", {63'd0, empty}, 64'd1);
        @(negedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1;
        applyStimulus(1'b1, 5'd9, 2'b00, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
        @(negedge clock);
        checkOutput("post_reset_disp_tag", {60'd0, disp_tag}, 64'd0);
        endCycle();
        checkOutput("post_reset_count", {59'd0, count}, 64'd1);

        repeat (2) endCycle();
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rob_nway.md
ROB_NWAY -- requirements
Module: rob_nway

Interface
REQ-001 Parameter DEPTH, default 16, entry count; power of two, at least 4.
REQ-002 Parameter XLEN, default 32, result value width.
REQ-003 Parameter REG_IDX_W, default 5, architectural destination index width.
REQ-004 Parameter CDB_N, default 2, number of completion (CDB) ports; TAG_W = clog2(DEPTH).
REQ-005 clock  in  1  single clock; all state updates on the rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 disp_valid  in  1  dispatch request.
REQ-008 disp_dest_idx  in  REG_IDX_W  destination register of the dispatched instruction.
REQ-009 disp_ready  out  1  entry available (not full).
REQ-010 disp_tag  out  TAG_W  tag assigned to this cycle's dispatch (current tail).
REQ-011 cdb_valid  in  CDB_N  per-port completion strobe.
REQ-012 cdb_tag  in  CDB_N*TAG_W  per-port completing tag.
REQ-013 cdb_value  in  CDB_N*XLEN  per-port result.
REQ-014 cdb_mispredict  in  CDB_N  per-port branch-mispredict flag.
REQ-015 lk_tag  in  2*TAG_W  two operand lookup tags.
REQ-016 lk_ready  out  2  per lookup: entry busy and done.
REQ-017 lk_value  out  2*XLEN  per lookup: stored value; 0 when lk_ready is 0.
REQ-018 ret_valid  out  1  head entry retires this cycle.
REQ-019 ret_dest_idx, ret_value, ret_tag  out  REG_IDX_W, XLEN, TAG_W  retiring entry fields.
REQ-020 ret_flush  out  1  retiring entry mispredicted; the ROB is flushed at the next edge.
REQ-021 count  out  TAG_W+1  occupied entries; empty  out  1  count==0.

Function
REQ-022 Each entry SHALL hold busy, done, mispredict, dest_idx and value; the tag SHALL be the entry index.
REQ-023 disp_ready SHALL be !full, computed from count before this cycle's retire; a slot freed by retire is usable next cycle.
REQ-024 A dispatch SHALL occur when disp_valid && disp_ready && !ret_flush.
- Entry[tail]: busy=1, done=0, mispredict=0, value=0, dest_idx written.
- tail increments modulo DEPTH.
REQ-025 A CDB port hit SHALL set done=1 and capture value and mispredict, only if the target entry is busy; hits on non-busy entries SHALL be ignored.
REQ-026 If two ports carry the same tag in one cycle, the lowest port index SHALL win.
REQ-027 ret_valid SHALL be combinational: head entry busy && done. Retire SHALL clear busy and increment head modulo DEPTH at the edge.
REQ-028 Retire, dispatch and CDB writes SHALL complete in the same cycle without conflict.
REQ-029 count SHALL be updated as count + dispatch - retire; dispatch when full and retire when empty SHALL be impossible.
REQ-030 ret_flush SHALL equal ret_valid && head mispredict. At that edge:
- every busy bit clears;
- head = tail = 0, count = 0;
- same-cycle dispatch and CDB writes are discarded.
REQ-031 Lookups SHALL be combinational, reading entry state from before this cycle's updates.

Reset
REQ-032 Asserting reset_n low SHALL immediately clear all busy and done bits and set head = tail = count = 0, independent of clock.
- Outputs: disp_ready=1, disp_tag=0, ret_valid=0, ret_flush=0, lk_ready=0, lk_value=0, count=0, empty=1.
- Reset mid-operation discards all entries; there SHALL be no partial retire.

Configuration
REQ-033 With macro ROB_CDB_FWD_EN defined: a lookup whose tag matches a same-cycle valid CDB port on a busy entry SHALL return lk_ready=1 with that port's value (lowest port wins). The lookup SHALL ignore forwarding when ret_flush is 1.
REQ-034 Without ROB_CDB_FWD_EN: lookups SHALL reflect registered state only; a CDB value becomes visible one cycle later.

Verification
REQ-035 Reset, then dispatch 16 instructions with DEPTH=16 -> tags 0..15, count=16, disp_ready=0; a 17th disp_valid is ignored.
REQ-036 Complete tag 1 before tag 0 (value 0xAA, then 0x55) -> no retire until tag 0 completes; then ret_value 0x55, then 0xAA on consecutive cycles.
REQ-037 Full ROB, retire and dispatch in the same cycle -> dispatch rejected, count=15 next cycle; dispatch accepted the following cycle with tag 0, exercising wrap-around.
REQ-038 Mispredict on head tag 3 with 5 entries busy -> ret_flush=1 for one cycle, then count=0, empty=1, disp_tag=0.
REQ-039 Both CDB ports hit tag 2 (values 7 and 9) -> stored value 7; with ROB_CDB_FWD_EN, same-cycle lk_tag=2 returns lk_ready=1, lk_value=7; without it, lk_ready=0 that cycle.
REQ-040 Assert reset_n low between clock edges with 4 entries busy -> outputs reach reset values before the next edge; ret_valid=0.
